// File: rtl/pipe_skid_buffer_sync_rst.sv
// Two-entry skid buffer with a registered ready path and synchronous reset.
// The main register drives m_data; the skid register absorbs one word of backpressure.
module pipe_skid_buffer_sync_rst #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] s_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data,
  output logic [1:0]       occupancy
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] main_q;
  logic [WIDTH-1:0] skid_q;

  // Ready depends only on state and reset, never on m_ready.
  assign s_ready   = !rst && (state != FULL);
  assign m_data    = main_q;
  assign occupancy = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= EMPTY;
      m_valid <= 1'b0;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      unique case (state)
        EMPTY: begin
          if (s_valid) begin
            main_q  <= s_data;
            m_valid <= 1'b1;
            state   <= ONE;
          end
        end
        ONE: begin
          if (s_valid && m_ready) begin
            main_q <= s_data;
          end else if (s_valid) begin
            skid_q <= s_data;
            state  <= FULL;
          end else if (m_ready) begin
            m_valid <= 1'b0;
            state   <= EMPTY;
          end
        end
        FULL: begin
          if (m_ready) begin
            main_q <= skid_q;
            state  <= ONE;
          end
        end
        default: begin
          state   <= EMPTY;
          m_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_skid_buffer_sync_rst.sv
// Directed table, streaming, and randomized scoreboard checks
// for the two-entry skid buffer.
module tb_pipe_skid_buffer_sync_rst;

  logic       clk = 1'b0;
  logic       rst;
  logic       s_valid;
  logic       s_ready;
  logic [7:0] s_data;
  logic       m_valid;
  logic       m_ready;
  logic [7:0] m_data;
  logic [1:0] occupancy;

  int checks = 0;
  int errors = 0;

  pipe_skid_buffer_sync_rst #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_data    (s_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .occupancy (occupancy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       sv;
    logic [7:0] sd;
    logic       mr;
    logic       mv;
    logic [7:0] md;
    logic [1:0] occ;
    logic       sr;
  } vec_t;

  vec_t vec [16];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  logic [7:0] exp_q [$];
  int         sent;
  int         recv;
  int         cyc;
  logic       hold;
  logic [7:0] held;
  logic [7:0] nxt;

  initial begin
    //          rst sv  sd     mr   mv  md     occ sr
    vec[0]  = '{1, 1, 8'hAA, 0,   0, 8'h00, 0, 0};
    vec[1]  = '{1, 1, 8'hAA, 0,   0, 8'h00, 0, 0};
    vec[2]  = '{0, 0, 8'hAA, 0,   0, 8'h00, 0, 1};
    vec[3]  = '{0, 1, 8'h11, 0,   1, 8'h11, 1, 1};
    vec[4]  = '{0, 1, 8'h22, 0,   1, 8'h11, 2, 0};
    vec[5]  = '{0, 1, 8'h33, 0,   1, 8'h11, 2, 0};
    vec[6]  = '{0, 0, 8'h33, 1,   1, 8'h22, 1, 1};
    vec[7]  = '{0, 0, 8'h33, 1,   0, 8'h22, 0, 1};
    vec[8]  = '{0, 1, 8'h44, 0,   1, 8'h44, 1, 1};
    vec[9]  = '{0, 1, 8'h55, 0,   1, 8'h44, 2, 0};
    vec[10] = '{1, 1, 8'h66, 1,   0, 8'h00, 0, 0};
    vec[11] = '{0, 0, 8'h66, 0,   0, 8'h00, 0, 1};
    vec[12] = '{0, 1, 8'h77, 1,   1, 8'h77, 1, 1};
    vec[13] = '{0, 1, 8'h88, 1,   1, 8'h88, 1, 1};
    vec[14] = '{0, 0, 8'h88, 0,   1, 8'h88, 1, 1};
    vec[15] = '{0, 0, 8'h88, 1,   0, 8'h88, 0, 1};

    rst     = 1'b1;
    s_valid = 1'b0;
    s_data  = 8'h00;
    m_ready = 1'b0;

    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      rst     = vec[i].rst;
      s_valid = vec[i].sv;
      s_data  = vec[i].sd;
      m_ready = vec[i].mr;
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d m_valid", i), 32'(m_valid), 32'(vec[i].mv));
      chk($sformatf("vec%0d m_data", i), 32'(m_data), 32'(vec[i].md));
      chk($sformatf("vec%0d occupancy", i), 32'(occupancy),
          32'(vec[i].occ));
      chk($sformatf("vec%0d s_ready", i), 32'(s_ready), 32'(vec[i].sr));
    end

    // Back-to-back streaming with downstream always ready.
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      s_valid = 1'b1;
      s_data  = 8'(i);
      m_ready = 1'b1;
      chk($sformatf("stream%0d s_ready_pre", i), 32'(s_ready), 32'd1);
      @(posedge clk);
      #1;
      chk($sformatf("stream%0d m_valid", i), 32'(m_valid), 32'd1);
      chk($sformatf("stream%0d m_data", i), 32'(m_data), 32'(i));
      chk($sformatf("stream%0d occupancy", i), 32'(occupancy), 32'd1);
    end
    @(negedge clk);
    s_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("stream drain m_valid", 32'(m_valid), 32'd0);
    chk("stream drain occupancy", 32'(occupancy), 32'd0);

    // Randomized handshakes against a queue scoreboard.
    sent = 0;
    recv = 0;
    cyc  = 0;
    nxt  = 8'h00;
    while (recv < 1000 && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      s_valid = (sent < 1000) && ($urandom_range(0, 1) == 1);
      s_data  = nxt;
      m_ready = ($urandom_range(0, 1) == 1);
      #1;
      hold = m_valid && !m_ready;
      held = m_data;
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          chk("rand pop_on_empty", 32'(m_valid), 32'd0);
        end else begin
          chk("rand order", 32'(m_data), 32'(exp_q[0]));
          void'(exp_q.pop_front());
        end
        recv++;
      end
      if (s_valid && s_ready) begin
        exp_q.push_back(s_data);
        nxt = nxt + 8'd1;
        sent++;
      end
      @(posedge clk);
      #1;
      chk("rand occupancy", 32'(occupancy), 32'(exp_q.size()));
      chk("rand m_valid", 32'(m_valid), 32'(exp_q.size() != 0));
      chk("rand s_ready", 32'(s_ready), 32'(exp_q.size() < 2));
      if (exp_q.size() != 0)
        chk("rand head", 32'(m_data), 32'(exp_q[0]));
      if (hold) begin
        chk("rand stable m_valid", 32'(m_valid), 32'd1);
        chk("rand stable m_data", 32'(m_data), 32'(held));
      end
    end
    chk("rand words received", 32'(recv), 32'd1000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_skid_buffer_sync_rst.md
PIPE_SKID_BUFFER_SYNC_RST -- requirements
Module: pipe_skid_buffer_sync_rst

Interface
REQ-001 SHALL have parameter: WIDTH, default 8, data payload width in bits (legal range >= 1).
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port: s_valid  input  1  upstream data valid.
REQ-005 SHALL have port: s_ready  output  1  buffer can accept upstream data.
REQ-006 SHALL have port: s_data  input  WIDTH  upstream payload.
REQ-007 SHALL have port: m_valid  output  1  downstream data valid.
REQ-008 SHALL have port: m_ready  input  1  downstream accepts data.
REQ-009 SHALL have port: m_data  output  WIDTH  downstream payload.
REQ-010 SHALL have port: occupancy  output  2  number of words held (0, 1 or 2).

Function
REQ-011 SHALL transfer a word upstream when s_valid && s_ready on a rising clk edge, and downstream when m_valid && m_ready on a rising clk edge.
REQ-012 SHALL implement a 2-entry skid buffer with a main register (drives m_data) and a skid register.
REQ-013 SHALL use a state machine: EMPTY (occupancy 0), ONE (occupancy 1), FULL (occupancy 2).
REQ-014 SHALL drive m_valid = 1 in ONE and FULL, and 0 in EMPTY.
REQ-015 SHALL drive s_ready = 1 in EMPTY and ONE, and 0 in FULL and while rst is high.
REQ-016 SHALL use these transitions from EMPTY: if s_valid, load main <= s_data and go to ONE; otherwise stay.
REQ-017 SHALL use these transitions from ONE:
- s_valid && m_ready: load main <= s_data and stay in ONE.
- s_valid && !m_ready: load skid <= s_data and go to FULL.
- !s_valid && m_ready: go to EMPTY.
- Otherwise: hold.
REQ-018 SHALL use these transitions from FULL: if m_ready, load main <= skid and go to ONE; otherwise hold; s_data is ignored in FULL.
REQ-019 SHALL have a latency of 1 cycle: a word accepted at edge N is presented on m_data with m_valid = 1 after edge N.
REQ-020 SHALL sustain throughput of 1 word/cycle when m_ready is held high.
REQ-021 SHALL preserve order: words exit in exactly the order accepted, with no loss or duplication.
REQ-022 SHALL hold m_data and m_valid stable while m_valid && !m_ready.
REQ-023 SHALL NOT modify a register that is not being loaded; main and skid retain value otherwise.
REQ-024 SHALL produce s_ready solely from state and rst, with no combinational path from m_ready to s_ready.
REQ-025 SHALL keep occupancy equal to the state encoding at all times.

Reset
REQ-026 SHALL, on a rising edge with rst = 1, set state to EMPTY, m_valid to 0, occupancy to 0, and main and skid to 0, so m_data = 0.
REQ-027 SHALL give rst priority over all handshakes; a transfer coinciding with a reset edge is discarded on both ports.
REQ-028 SHALL, when reset is applied mid-operation (ONE or FULL), discard all held words; after rst deasserts, s_ready = 1 and m_valid = 0.

Verification
REQ-029 SHALL cover: rst high for 2 cycles with s_valid = 1, s_data = 0xAA -> after release m_valid = 0, m_data = 0x00, occupancy = 0, s_ready = 1; no 0xAA output.
REQ-030 SHALL cover: m_ready = 1 and stream 0x01..0x10 back-to-back -> each word exits 1 cycle after acceptance, 16 words in 16 consecutive cycles, s_ready stays 1.
REQ-031 SHALL cover: m_ready = 0, send 0x11 then 0x22 -> occupancy 1 then 2, s_ready = 0, m_data = 0x11 held; then a third word 0x33 offered is not accepted.
REQ-032 SHALL cover: from FULL (0x11, 0x22), raise m_ready for 2 cycles with s_valid = 0 -> outputs 0x11 then 0x22, occupancy 2 -> 1 -> 0.
REQ-033 SHALL cover: random s_valid/m_ready (50%) over 1000 words -> a scoreboard sees in-order, lossless output, and m_data stable whenever m_valid && !m_ready.
REQ-034 SHALL cover: assert rst for 1 cycle while in FULL -> next cycle occupancy = 0, m_valid = 0, and the old words never appear.
